// File: rtl/wave_layer_engine.sv
// wave_layer_engine: parallax sine-wave layers under an overlay band.
// Two-stage registered pixel pipeline, animated by a v_sync-driven counter.
module wave_layer_engine #(
  parameter int LAYERS     = 2,
  parameter int CW         = 2,
  parameter int FRAME_W    = 10,
  parameter int BASE_SHIFT = 3,
  parameter int ROW_OFF    = 3,
  parameter int OVL_H      = 32,
  parameter logic [LAYERS*3*CW-1:0] LAYER_RGB =
    {6'b00_11_11, 6'b00_01_10}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          frame_active,
  input  logic          v_sync,
  input  logic          pause,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          frame_tick
);

  localparam int PW = 3 * CW;
  localparam logic [10:0] OVL_LIM = 11'(OVL_H);

  localparam logic [4:0] SIN [64] = '{
    5'd16, 5'd17, 5'd19, 5'd20, 5'd21, 5'd23, 5'd24, 5'd25,
    5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd30, 5'd31, 5'd31,
    5'd31, 5'd31, 5'd31, 5'd30, 5'd30, 5'd29, 5'd28, 5'd27,
    5'd26, 5'd25, 5'd24, 5'd23, 5'd21, 5'd20, 5'd19, 5'd17,
    5'd16, 5'd14, 5'd12, 5'd11, 5'd10, 5'd8,  5'd7,  5'd6,
    5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd1,  5'd0,  5'd0,
    5'd0,  5'd0,  5'd0,  5'd1,  5'd1,  5'd2,  5'd3,  5'd4,
    5'd5,  5'd6,  5'd7,  5'd8,  5'd10, 5'd11, 5'd12, 5'd14
  };

  logic               vs_q;
  logic               vs_edge;
  logic [FRAME_W-1:0] ctr;

  logic [5:0]  idx_d [LAYERS];
  logic [5:0]  row_d [LAYERS];
  logic [5:0]  idx_q [LAYERS];
  logic [5:0]  row_q [LAYERS];
  logic        g0_q;
  logic        gn_q;
  logic        ovl_q;
  logic        fa_q;
  logic [PW-1:0] oc_d;
  logic [PW-1:0] oc_q;
  logic [PW-1:0] pix_d;

  // Column index into the sine table for layer k (scrolled, scaled).
  function automatic logic [5:0] idx_of(
    input logic [9:0]         px,
    input logic [FRAME_W-1:0] c,
    input int                 k
  );
    logic [31:0] off;
    logic [9:0]  sum;
    off = 32'(c) << k;
    sum = px + off[9:0];
    return 6'(sum >> (BASE_SHIFT - k));
  endfunction

  // Row within layer k's band, modulo 64.
  function automatic logic [5:0] row_of(
    input logic [9:0] py,
    input int         k
  );
    logic [9:0] t;
    t = py >> (BASE_SHIFT - k + 1);
    return 6'(t - 10'(ROW_OFF));
  endfunction

  assign vs_edge = v_sync & ~vs_q;

  // Frame counter: one tick per v_sync rising edge, pause freezes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      ctr        <= '0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= v_sync;
      frame_tick <= vs_edge;
      if (vs_edge && !pause)
        ctr <= ctr + 1'b1;
    end
  end

  // Stage 1 address math for every layer plus overlay colour.
  always_comb begin
    for (int k = 0; k < LAYERS; k++) begin
      idx_d[k] = idx_of(x, ctr, k);
      row_d[k] = row_of(y, k);
    end
    oc_d = {{CW{ctr[7]}}, {CW{ctr[6]}}, {CW{ctr[5]}}};
  end

  // Stage 1 register: pixel geometry sampled with the current ctr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LAYERS; k++) begin
        idx_q[k] <= '0;
        row_q[k] <= '0;
      end
      g0_q  <= 1'b0;
      gn_q  <= 1'b0;
      ovl_q <= 1'b0;
      fa_q  <= 1'b0;
      oc_q  <= '0;
    end else begin
      for (int k = 0; k < LAYERS; k++) begin
        idx_q[k] <= idx_d[k];
        row_q[k] <= row_d[k];
      end
      g0_q  <= x[0] ^ y[0];
      gn_q  <= x[0] & y[0];
      ovl_q <= {1'b0, y} < OVL_LIM;
      fa_q  <= frame_active;
      oc_q  <= oc_d;
    end
  end

  // Stage 2 lookup, fill test and front-to-back priority select.
  always_comb begin
    pix_d = '0;
    for (int k = LAYERS - 1; k >= 0; k--) begin
      if (!row_q[k][5] &&
          (row_q[k][4:0] >= SIN[idx_q[k]]) &&
          ((k == 0) ? g0_q : gn_q))
        pix_d = LAYER_RGB[(LAYERS-k)*PW-1 -: PW];
    end
    if (ovl_q)
      pix_d = oc_q;
    if (!fa_q)
      pix_d = '0;
  end

  // Stage 2 register: colour outputs.
  always_ff @(posedge clk) begin
    if (!rst_n)
      {r, g, b} <= '0;
    else
      {r, g, b} <= pix_d;
  end

endmodule

// File: tb/tb_wave_layer_engine.sv
// tb_wave_layer_engine: randomized and directed checks
// against a behavioural pixel/counter model.
module tb_wave_layer_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       frame_active = 1'b0;
  logic       v_sync = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] r, g, b;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int mctr = 0;

  always #5 clk = ~clk;

  wave_layer_engine dut (
    .clk(clk),
    .rst_n(rst_n),
    .x(x),
    .y(y),
    .frame_active(frame_active),
    .v_sync(v_sync),
    .pause(pause),
    .r(r),
    .g(g),
    .b(b),
    .frame_tick(frame_tick)
  );

  function automatic int sinv(int i);
    real v;
    v = 15.5 + 15.5 * $sin(2.0 * 3.141592653589793 * i / 64.0);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic logic [5:0] model(int px, int py, bit fa, int c);
    int s, off, idx, row;
    bit gate, hit;
    logic [5:0] col [2];
    col[0] = 6'b00_11_11;
    col[1] = 6'b00_01_10;
    if (!fa) return 6'd0;
    if (py < 32)
      return 6'(((c >> 7) & 1) * 48 + ((c >> 6) & 1) * 12
                + ((c >> 5) & 1) * 3);
    for (int k = 0; k < 2; k++) begin
      s = 3 - k;
      off = (c * (1 << k)) % 1024;
      idx = (((px + off) % 1024) / (1 << s)) % 64;
      row = ((py / (1 << (s + 1))) - 3 + 64) % 64;
      hit = (row < 32) && (row >= sinv(idx));
      if (k == 0) gate = ((px + py) % 2) == 1;
      else gate = (px % 2 == 1) && (py % 2 == 1);
      if (hit && gate) return col[k];
    end
    return 6'd0;
  endfunction

  task automatic drive(int px, int py, bit fa);
    x = 10'(px);
    y = 10'(py);
    frame_active = fa;
  endtask

  task automatic pix(int px, int py, bit fa,
                     logic [5:0] exp, string nm);
    @(negedge clk);
    drive(px, py, fa);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({r, g, b} !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, {r, g, b}, exp);
    end
  endtask

  task automatic pulse(int hi, output int ticks);
    ticks = 0;
    @(negedge clk);
    v_sync = 1'b1;
    for (int i = 0; i < hi + 2; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ticks++;
      if (i == hi - 1) v_sync = 1'b0;
    end
    if (!pause) mctr = (mctr + 1) % 1024;
  endtask

  task automatic pulses(int n);
    int t;
    for (int i = 0; i < n; i++) pulse(1, t);
  endtask

  task automatic test_random(int n, string nm);
    logic [5:0] q[$];
    logic [5:0] e;
    int px, py;
    bit fa;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = q.pop_front();
        checks++;
        if ({r, g, b} !== e) begin
          errors++;
          $display("FAIL %s[%0d] ctr=%0d: got %b expected %b",
                   nm, i - 2, mctr, {r, g, b}, e);
        end
      end
      if (i < n) begin
        px = int'($urandom_range(1023, 0));
        py = int'($urandom_range(575, 0));
        fa = ($urandom_range(7, 0) != 0);
        drive(px, py, fa);
        q.push_back(model(px, py, fa, mctr));
      end else begin
        drive(0, 600, 1'b0);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({r, g, b} !== 6'd0) begin
        errors++;
        $display("FAIL reset_rgb: got %b expected 0", {r, g, b});
      end
      checks++;
      if (frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_tick: got %b expected 0", frame_tick);
      end
    end
    rst_n = 1'b1;
    drive(1, 304, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({r, g, b} !== 6'b001111) begin
      errors++;
      $display("FAIL reset_first_pix: got %b expected 001111",
               {r, g, b});
    end
    mctr = 0;
  endtask

  task automatic test_layer0;
    pix(1, 304, 1'b1, 6'b001111, "l0_hit");
    pix(1, 288, 1'b1, 6'b000000, "l0_row15");
    pix(0, 304, 1'b1, 6'b000000, "l0_gated");
    test_random(40, "rand_ctr0");
  endtask

  task automatic test_counter;
    int t;
    for (int i = 0; i < 5; i++) begin
      pulse(1, t);
      checks++;
      if (t != 1) begin
        errors++;
        $display("FAIL tick_pulse%0d: got %0d ticks expected 1", i, t);
      end
    end
    test_random(40, "rand_ctr5");
    pulse(100, t);
    checks++;
    if (t != 1) begin
      errors++;
      $display("FAIL tick_hold: got %0d ticks expected 1", t);
    end
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse(1, t);
      checks++;
      if (t != 1) begin
        errors++;
        $display("FAIL tick_paused%0d: got %0d expected 1", i, t);
      end
    end
    pause = 1'b0;
    test_random(60, "rand_paused");
  endtask

  task automatic test_scroll;
    pulses(8 - mctr);
    pix(1, 320, 1'b1, 6'b001111, "scroll_l0_hit");
    pix(1, 304, 1'b1, 6'b000000, "scroll_l0_miss");
    pix(1, 193, 1'b1, 6'b000110, "scroll_l1_hit");
    pix(1, 185, 1'b1, 6'b000000, "scroll_l1_miss");
    test_random(60, "rand_ctr8");
  endtask

  task automatic test_overlay;
    pulses(8'hDF - mctr);
    pix(5, 10, 1'b1, 6'b111100, "ovl_df");
    @(negedge clk);
    drive(5, 10, 1'b1);
    v_sync = 1'b1;
    @(negedge clk);
    v_sync = 1'b0;
    @(negedge clk);
    checks++;
    if ({r, g, b} !== 6'b111100) begin
      errors++;
      $display("FAIL edge_old_ctr: got %b expected 111100", {r, g, b});
    end
    @(negedge clk);
    checks++;
    if ({r, g, b} !== 6'b111111) begin
      errors++;
      $display("FAIL edge_new_ctr: got %b expected 111111", {r, g, b});
    end
    mctr = 8'hE0;
    pix(5, 10, 1'b0, 6'b000000, "ovl_inactive");
    test_random(80, "rand_ctrE0");
  endtask

  task automatic test_reset_mid;
    pix(5, 10, 1'b1, 6'b111111, "pre_reset_ovl");
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({r, g, b} !== 6'd0) begin
      errors++;
      $display("FAIL reset_same_edge: got %b expected 0", {r, g, b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    mctr = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({r, g, b} !== 6'd0) begin
      errors++;
      $display("FAIL reset_ctr_cleared: got %b expected 0", {r, g, b});
    end
    pix(1, 304, 1'b1, 6'b001111, "post_reset_l0");
  endtask

  task automatic test_wrap;
    int t;
    pulses(1023);
    pix(5, 10, 1'b1, 6'b111111, "ovl_1023");
    test_random(40, "rand_ctr1023");
    pulse(1, t);
    checks++;
    if (t != 1) begin
      errors++;
      $display("FAIL tick_wrap: got %0d expected 1", t);
    end
    pix(5, 10, 1'b1, 6'b000000, "ovl_wrapped");
    pix(1, 304, 1'b1, 6'b001111, "wrap_l0");
    pulses(4);
    pix(1021, 161, 1'b1, 6'b000110, "xwrap_l1");
    test_random(60, "rand_ctr4");
  endtask

  initial begin
    test_reset();
    test_layer0();
    test_counter();
    test_scroll();
    test_overlay();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
